// File: rtl/trap_filter_param.sv
// Runtime-configurable trapezoidal / pole-zero shaping filter with peak detector.
// Five-stage pipeline from input sample to output_data; config changes flush the datapath.
module trap_filter_param #(
  parameter int unsigned SIZE_ADC_DATA    = 12,
  parameter int unsigned SIZE_FILTER_DATA = 24,
  parameter int unsigned ACC_W            = 40,
  parameter int unsigned MAX_DEPTH        = 64,
  parameter int unsigned DEPTH_W          = 7,
  parameter int unsigned M_W              = 10,
  parameter int unsigned SHIFT            = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic        [SIZE_ADC_DATA-1:0]    input_data,
  input  logic                               cfg_load,
  input  logic        [DEPTH_W-1:0]          k_cfg,
  input  logic        [DEPTH_W-1:0]          l_cfg,
  input  logic        [M_W-1:0]              m_cfg,
  input  logic                               mode_cfg,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  output logic signed [SIZE_FILTER_DATA-1:0] output_data,
  output logic                               out_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
  output logic                               peak_valid,
  output logic        [15:0]                 peak_count,
  output logic                               cfg_err
);

  localparam int DlLen  = 2 * MAX_DEPTH;
  localparam int IdxW   = $clog2(DlLen);
  localparam int TapW   = DEPTH_W + 1;
  localparam int FlushW = DEPTH_W + 2;

  localparam logic signed [ACC_W-1:0] OutMax =
    {{(ACC_W - SIZE_FILTER_DATA + 1){1'b0}}, {(SIZE_FILTER_DATA - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OutMin =
    {{(ACC_W - SIZE_FILTER_DATA + 1){1'b1}}, {(SIZE_FILTER_DATA - 1){1'b0}}};

  typedef enum logic {StIdle, StArmed} peak_state_e;

  // Active configuration
  logic [DEPTH_W-1:0] k_q, l_q;
  logic [M_W-1:0]     m_q;
  logic               mode_q;
  logic [FlushW-1:0]  flush_q;
  logic               cfg_ok;
  logic               cfg_err_q;

  // Datapath
  logic        [SIZE_ADC_DATA-1:0] x_q;
  logic        [SIZE_ADC_DATA-1:0] dl_q [DlLen];
  logic signed [ACC_W-1:0]         d_q, d3_q, p_q, p4_q, p5_q, r_q, s_q;
  logic signed [ACC_W-1:0]         d_next, r_next, m_ext;
  logic        [TapW-1:0]          kl_sum;
  logic        [IdxW-1:0]          idx_k, idx_l, idx_kl;
  logic signed [ACC_W-1:0]         sel, shifted, sat;

  // Peak detector
  peak_state_e                      state_q, state_d;
  logic signed [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic signed [SIZE_FILTER_DATA-1:0] peak_value_q, peak_value_d;
  logic                             peak_valid_q, peak_valid_d;
  logic        [15:0]               peak_count_q, peak_count_d;

  function automatic logic signed [ACC_W-1:0] ext(input logic [SIZE_ADC_DATA-1:0] v);
    return $signed({{(ACC_W - SIZE_ADC_DATA){1'b0}}, v});
  endfunction

  assign cfg_ok = cfg_load && (k_cfg != '0) && (k_cfg <= l_cfg) &&
                  (TapW'(l_cfg) <= TapW'(MAX_DEPTH));

  // dl_q[j-1] holds x(n-j) while x_q holds x(n)
  assign kl_sum = TapW'(k_q) + TapW'(l_q) - TapW'(1);
  assign idx_k  = IdxW'(k_q - DEPTH_W'(1));
  assign idx_l  = IdxW'(l_q - DEPTH_W'(1));
  assign idx_kl = IdxW'(kl_sum);

  assign d_next = ext(x_q) - ext(dl_q[idx_k]) - ext(dl_q[idx_l]) + ext(dl_q[idx_kl]);
  assign m_ext  = $signed({{(ACC_W - M_W){1'b0}}, m_q});
  assign r_next = p_q + m_ext * d3_q;

  always_ff @(posedge clk) begin
    if (reset || cfg_ok) begin
      x_q  <= '0;
      for (int i = 0; i < DlLen; i++) dl_q[i] <= '0;
      d_q  <= '0;
      d3_q <= '0;
      p_q  <= '0;
      p4_q <= '0;
      p5_q <= '0;
      r_q  <= '0;
      s_q  <= '0;
    end else begin
      x_q     <= input_data;
      dl_q[0] <= x_q;
      for (int i = 1; i < DlLen; i++) dl_q[i] <= dl_q[i-1];
      d_q  <= d_next;
      d3_q <= d_q;
      p_q  <= p_q + d_q;
      p4_q <= p_q;
      p5_q <= p4_q;
      r_q  <= r_next;
      s_q  <= s_q + r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q       <= DEPTH_W'(1);
      l_q       <= DEPTH_W'(1);
      m_q       <= '0;
      mode_q    <= 1'b0;
      flush_q   <= FlushW'(7);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        k_q     <= k_cfg;
        l_q     <= l_cfg;
        m_q     <= m_cfg;
        mode_q  <= mode_cfg;
        flush_q <= FlushW'(k_cfg) + FlushW'(l_cfg) + FlushW'(5);
      end else if (flush_q != '0) begin
        flush_q <= flush_q - FlushW'(1);
      end
    end
  end

  always_comb begin
    sel     = mode_q ? s_q : p5_q;
    shifted = sel >>> SHIFT;
    sat     = shifted;
    if (shifted > OutMax)      sat = OutMax;
    else if (shifted < OutMin) sat = OutMin;
  end

  assign output_data = SIZE_FILTER_DATA'(sat);
  assign out_valid   = (flush_q == '0);
  assign cfg_err     = cfg_err_q;

  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    peak_value_d = peak_value_q;
    peak_valid_d = 1'b0;
    peak_count_d = peak_count_q;
    if (cfg_ok) begin
      // A pulse cut by a reconfiguration is discarded
      state_d = StIdle;
    end else if (out_valid) begin
      case (state_q)
        StIdle: begin
          if (output_data > threshold) begin
            state_d = StArmed;
            max_d   = output_data;
          end
        end
        StArmed: begin
          if (output_data > max_q) max_d = output_data;
          if (output_data <= threshold) begin
            state_d      = StIdle;
            peak_value_d = max_q;
            peak_valid_d = 1'b1;
            peak_count_d = peak_count_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      max_q        <= '0;
      peak_value_q <= '0;
      peak_valid_q <= 1'b0;
      peak_count_q <= '0;
    end else begin
      state_q      <= state_d;
      max_q        <= max_d;
      peak_value_q <= peak_value_d;
      peak_valid_q <= peak_valid_d;
      peak_count_q <= peak_count_d;
    end
  end

  assign peak_value = peak_value_q;
  assign peak_valid = peak_valid_q;
  assign peak_count = peak_count_q;

endmodule

// File: doc/trap_filter_param.md
Name: trap_filter_param

Overview:
- Parametrised successor to the fixed v1 shaping filter.
- Runtime-configurable trapezoidal/pole-zero shaping filter for exponential pulses from exp_sig_gen: selectable rise (k) and flat-top (l) lengths, pole-zero constant m, and step/exponential mode.
- Built-in peak detector reports pulse amplitude with a one-cycle strobe plus a peak counter.
- Sits in the filter top beside/replacing v1..v5, fed by output_data_exp_sig_gen.

Parameters:
SIZE_ADC_DATA, 12, unsigned input sample width
SIZE_FILTER_DATA, 24, signed output width
ACC_W, 40, signed internal accumulator width
MAX_DEPTH, 64, max k and l; delay line length 2*MAX_DEPTH
DEPTH_W, 7, width of k_cfg/l_cfg (clog2(MAX_DEPTH)+1)
M_W, 10, unsigned width of m_cfg
SHIFT, 0, arithmetic right shift applied before output saturation

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high
input_data  in  SIZE_ADC_DATA  ADC sample, one per clock, zero-extended to signed
cfg_load  in  1  latch k_cfg/l_cfg/m_cfg/mode_cfg this cycle
k_cfg  in  DEPTH_W  rise length k
l_cfg  in  DEPTH_W  delay l (flat top = l-k)
m_cfg  in  M_W  pole-zero multiplier m
mode_cfg  in  1  0 = step mode (output p), 1 = exponential mode (output s)
threshold  in  SIZE_FILTER_DATA  signed peak-detect threshold, sampled live
output_data  out  SIZE_FILTER_DATA  shaped signal
out_valid  out  1  output_data meaningful (not flushing)
peak_value  out  SIZE_FILTER_DATA  last detected maximum
peak_valid  out  1  one-cycle strobe on peak_value update
peak_count  out  16  number of peaks detected, wraps at 65535->0
cfg_err  out  1  one-cycle strobe: cfg_load rejected

Behaviour:
- Reset: all outputs 0; delay line, accumulators zeroed; config = k=1, l=1, m=0, mode=0; flush counter loaded with k+l+5 (=7); peak FSM IDLE.
- Pipeline (x = input): S1 register x(n); S2 d(n)=x(n)-x(n-k)-x(n-l)+x(n-k-l); S3 p(n)=p(n-1)+d(n), d delayed; S4 r(n)=p(n)+m*d(n); S5 s(n)=s(n-1)+r(n).
- Latency: input sample on cycle n affects output_data on cycle n+5 (both modes; mode 0 presents p delayed to match).
- All arithmetic signed ACC_W, wraps internally; output = saturate(selected >>> SHIFT) to SIZE_FILTER_DATA (clamp to max positive/min negative).
- Delay line: 2*MAX_DEPTH shift register, taps at k, l, k+l, selected from the active config.
- cfg_load: valid iff 1<=k<=l<=MAX_DEPTH. Valid: new config active next cycle; delay line, p, s and pipeline cleared; out_valid low for k+l+5 cycles, then high; peak FSM forced IDLE; no peak_valid during flush. Invalid: cfg_err=1 for one cycle, config and state unchanged. cfg_load on consecutive cycles: each evaluated; the last valid one wins and restarts the flush.
- Peak FSM (evaluated only when out_valid=1):
  - IDLE: output_data > threshold -> ARMED, max <= output_data.
  - ARMED: max <= max(max, output_data); output_data <= threshold -> emit peak_value=max, peak_valid=1, peak_count+1, return to IDLE.
  - out_valid falling (cfg_load) while ARMED -> IDLE, no emission.
- Equal-to-threshold does not arm.
- threshold changes take effect the same cycle.
- reset mid-operation: identical to power-on reset, from the next edge.

Test Plan:
- Reset, hold 0 input: output_data=0, out_valid rises 7 cycles after reset release, peak_valid never asserts.
- mode=0, k=4, l=8, SHIFT=0, baseline 0 then step to 100 at cycle n: output from n+5: 100,200,300,400, 400 x4, then 300,200,100,0 held.
- mode=1, k=4, l=8, m=1, input 1024>>i (i=0..) pulse: flat top 8192 +/-8 for 4 cycles, returns to 0 +/-8; with threshold=4000: one peak_valid, peak_value in 8184..8192, peak_count=1.
- cfg_load with k=9, l=5, then k=0: cfg_err pulses twice; outputs continue with old config; out_valid stays high.
- Valid cfg_load while ARMED mid-pulse: no peak_valid; out_valid low exactly k+l+5 cycles; count unchanged.
- Input 4095 constant, mode=1, m=1023, SIZE_FILTER_DATA=24: output saturates at 8388607, never wraps negative.
